mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive IF losses before IF is forced to win (fixed-priority mode only).
REQ-002 SHALL have ports clk input 1 (the single clock) and rst input 1 (asynchronous, active-low reset).
REQ-003 SHALL have IF (instruction-fetch) requester ports if_req in 1, if_addr in 32, if_gnt out 1, if_rvalid out 1, if_rdata out 32.
REQ-004 SHALL have DM (data-memory) requester ports dm_req in 1, dm_wr in 1, dm_addr in 32, dm_wdata in 32, dm_length in 2, dm_sign in 1, dm_gnt out 1, dm_rvalid out 1, dm_rdata out 32, dm_err out 1.
REQ-005 SHALL have memory-side ports mem_enable out 1, mem_wr out 1, mem_addr out 32, mem_data_in out 32, mem_length out 2, mem_sign out 1, and mem_data_out in 32 (combinational read data, write on rising edge).
REQ-006 SHALL have busy out 1, asserted whenever the FSM is not IDLE.

Function
REQ-007 SHALL implement the FSM states IDLE, ACC_IF and ACC_DM, with ACC_IF->IDLE and ACC_DM->IDLE taken unconditionally, giving at most one access per 2 cycles.
REQ-008 In IDLE with one requester active, the FSM SHALL go to that requester's ACC state at the next edge; with neither active it SHALL stay in IDLE.
REQ-009 On entry to an ACC state, addr, wr, wdata, length and sign SHALL be latched from the winning requester at the IDLE->ACC edge; later changes to the requester inputs SHALL be ignored.
REQ-010 x_gnt SHALL be high for exactly the one ACC cycle; requesters SHALL hold x_req and its fields until x_gnt is seen.
REQ-011 mem_enable SHALL be high only in ACC states; all mem_* outputs SHALL be 0 in IDLE.
REQ-012 ACC_IF SHALL drive mem_wr=0, mem_length=2'b10, mem_sign=0 and mem_addr = latched if_addr.
REQ-013 ACC_DM SHALL drive the latched DM fields unchanged.
REQ-014 Read data SHALL be registered from mem_data_out at the end of the ACC cycle; x_rvalid SHALL pulse for one cycle in the following IDLE cycle (latency: request seen in cycle N -> rvalid in N+2).
REQ-015 x_rdata SHALL hold its value until the next rvalid for that port.
REQ-016 A DM write SHALL also produce a one-cycle dm_rvalid acknowledge, with dm_rdata=0.
REQ-017 dm_length=2'b11 SHALL be granted but SHALL drive mem_enable=0 in ACC_DM, then pulse dm_rvalid and dm_err together with dm_rdata=0.
REQ-018 When both requesters are active in IDLE, the winner SHALL be chosen per the Configuration section.
REQ-019 A requester that drops x_req in IDLE before winning SHALL not be granted, and no memory access SHALL occur for it.
REQ-020 After ACC, the IDLE cycle SHALL re-arbitrate, so back-to-back requests are serviced every 2 cycles.

Reset
REQ-021 rst low SHALL immediately force IDLE, all outputs 0 (including rdata registers and dm_err), starve counter 0 and RR pointer = DM.
REQ-022 Reset during ACC_DM write SHALL deassert mem_enable combinationally so no write occurs at the next edge.
REQ-023 Reset during ACC_DM write SHALL produce no rvalid after reset release.
REQ-024 Reset release SHALL be followed by normal arbitration from the first edge at which rst is high.

Configuration
REQ-025 Macro MEM_ARB_RR_EN SHALL select the contention policy.
REQ-026 With MEM_ARB_RR_EN defined: round-robin; the port not granted last wins; the pointer updates on each grant; the pointer resets to DM so IF wins the first contention; STARVE_LIMIT is unused.
REQ-027 Without MEM_ARB_RR_EN: DM has fixed priority.
REQ-028 Without MEM_ARB_RR_EN: a 4-bit counter SHALL count IDLE cycles in which IF requested but DM won.
REQ-029 Without MEM_ARB_RR_EN: when the counter equals STARVE_LIMIT, IF SHALL win the next contention and the counter SHALL clear.
REQ-030 Without MEM_ARB_RR_EN: the counter SHALL also clear whenever IF is granted.

Verification
REQ-031 IF only: if_req=1, if_addr=0x100, mem word 0x11223344 -> if_gnt in cycle 1, mem_length=2'b10, if_rvalid in cycle 2 with if_rdata=0x11223344.
REQ-032 DM write then read: write, length=2'b01, addr 0x20, data 0xBEEF -> dm_rvalid ack with rdata 0; then signed byte read at 0x20 -> dm_rdata=0xFFFFFFBE.
REQ-033 Contention, fixed priority, STARVE_LIMIT=4: both requesting continuously -> DM granted 4 times, IF 5th, then the pattern repeats.
REQ-034 Contention, MEM_ARB_RR_EN: both requesting continuously -> grants alternate IF, DM, IF, DM.
REQ-035 Illegal length: dm_length=2'b11 -> mem_enable stays 0, dm_rvalid=dm_err=1 for one cycle.
REQ-036 Reset mid-write: rst low during ACC_DM write to 0x40 -> memory byte at 0x40 unchanged, all outputs 0, no dm_rvalid after release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle for mem_port_arbiter.
// master: the arbiter view (drives grants, read returns, memory port).
// slave : the environment view (requesters plus the memory's read data).
interface mem_port_arbiter_if;
  // instruction-fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  // data-memory requester
  logic        dm_req;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_length;
  logic        dm_sign;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  // memory port
  logic        mem_enable;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_length;
  logic        mem_sign;
  logic [31:0] mem_data_out;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_wr, dm_addr, dm_wdata, dm_length, dm_sign,
    output dm_gnt, dm_rvalid, dm_rdata, dm_err,
    output mem_enable, mem_wr, mem_addr, mem_data_in, mem_length, mem_sign,
    input  mem_data_out
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_wr, dm_addr, dm_wdata, dm_length, dm_sign,
    input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
    input  mem_enable, mem_wr, mem_addr, mem_data_in, mem_length, mem_sign,
    output mem_data_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / DM) arbiter in front of a single-ported memory.
// IDLE -> ACC_x -> IDLE, so at most one access every two cycles; read data
// is captured at the end of the ACC cycle and returned with x_rvalid in the
// following IDLE cycle, which also re-arbitrates.
// Contention policy: define MEM_ARB_RR_EN for round-robin; otherwise DM has
// fixed priority and IF is forced through after STARVE_LIMIT consecutive
// losses.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM} state_e;

  state_e      state_q, state_d;
  logic        if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic        if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic        dm_err_q, dm_err_d;
  logic        mem_enable_q, mem_enable_d, mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_data_in_q, mem_data_in_d;
  logic [1:0]  mem_length_q, mem_length_d;
  logic        mem_sign_q, mem_sign_d;
  logic        pick_if, pick_dm;

`ifdef MEM_ARB_RR_EN
  // 1: DM was granted last, so IF wins the next contention
  logic        rr_dm_last_q, rr_dm_last_d;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0]  starve_q, starve_d;
`endif

  // Winner selection in IDLE and policy-state update
  always_comb begin
    pick_if = 1'b0;
    pick_dm = 1'b0;
    if (state_q == IDLE) begin
      if (bus.if_req && bus.dm_req) begin
`ifdef MEM_ARB_RR_EN
        pick_if = rr_dm_last_q;
        pick_dm = !rr_dm_last_q;
`else
        pick_if = (starve_q == LIMIT);
        pick_dm = (starve_q != LIMIT);
`endif
      end else begin
        pick_if = bus.if_req;
        pick_dm = bus.dm_req;
      end
    end
`ifdef MEM_ARB_RR_EN
    rr_dm_last_d = pick_dm ? 1'b1 : (pick_if ? 1'b0 : rr_dm_last_q);
`else
    if (pick_if)                    starve_d = 4'd0;
    else if (pick_dm && bus.if_req) starve_d = starve_q + 4'd1;
    else                            starve_d = starve_q;
`endif
  end

  // Next-state and next-output computation; every output is registered so
  // all mem_* fields drop to zero on the ACC->IDLE edge
  always_comb begin
    state_d       = IDLE;
    if_gnt_d      = 1'b0;
    dm_gnt_d      = 1'b0;
    if_rvalid_d   = 1'b0;
    dm_rvalid_d   = 1'b0;
    dm_err_d      = 1'b0;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    mem_enable_d  = 1'b0;
    mem_wr_d      = 1'b0;
    mem_addr_d    = 32'd0;
    mem_data_in_d = 32'd0;
    mem_length_d  = 2'b00;
    mem_sign_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_dm) begin
          state_d       = ACC_DM;
          dm_gnt_d      = 1'b1;
          // length 2'b11 is granted but never reaches the memory
          mem_enable_d  = (bus.dm_length != 2'b11);
          mem_wr_d      = bus.dm_wr;
          mem_addr_d    = bus.dm_addr;
          mem_data_in_d = bus.dm_wdata;
          mem_length_d  = bus.dm_length;
          mem_sign_d    = bus.dm_sign;
        end else if (pick_if) begin
          state_d      = ACC_IF;
          if_gnt_d     = 1'b1;
          mem_enable_d = 1'b1;
          mem_addr_d   = bus.if_addr;
          mem_length_d = 2'b10;
        end
      end
      ACC_IF: begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = bus.mem_data_out;
      end
      ACC_DM: begin
        dm_rvalid_d = 1'b1;
        dm_err_d    = (mem_length_q == 2'b11);
        dm_rdata_d  = (mem_wr_q || mem_length_q == 2'b11) ? 32'd0 : bus.mem_data_out;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers; async reset clears mem_enable at once so an
  // in-flight write never lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      if_gnt_q      <= 1'b0;
      dm_gnt_q      <= 1'b0;
      if_rvalid_q   <= 1'b0;
      dm_rvalid_q   <= 1'b0;
      dm_err_q      <= 1'b0;
      if_rdata_q    <= 32'd0;
      dm_rdata_q    <= 32'd0;
      mem_enable_q  <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_data_in_q <= 32'd0;
      mem_length_q  <= 2'b00;
      mem_sign_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_dm_last_q  <= 1'b1;
`else
      starve_q      <= 4'd0;
`endif
    end else begin
      state_q       <= state_d;
      if_gnt_q      <= if_gnt_d;
      dm_gnt_q      <= dm_gnt_d;
      if_rvalid_q   <= if_rvalid_d;
      dm_rvalid_q   <= dm_rvalid_d;
      dm_err_q      <= dm_err_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      mem_enable_q  <= mem_enable_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_length_q  <= mem_length_d;
      mem_sign_q    <= mem_sign_d;
`ifdef MEM_ARB_RR_EN
      rr_dm_last_q  <= rr_dm_last_d;
`else
      starve_q      <= starve_d;
`endif
    end
  end

  assign busy            = (state_q != IDLE);
  assign bus.if_gnt      = if_gnt_q;
  assign bus.if_rvalid   = if_rvalid_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_gnt      = dm_gnt_q;
  assign bus.dm_rvalid   = dm_rvalid_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.dm_err      = dm_err_q;
  assign bus.mem_enable  = mem_enable_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.mem_length  = mem_length_q;
  assign bus.mem_sign    = mem_sign_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a big-endian byte memory model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if mif();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (mif.master),
    .busy (busy)
  );

  // memory model: 512 bytes, big-endian, length 00/01/10 = byte/half/word
  logic [7:0] mem [0:511];
  logic       pl_we = 1'b0;
  logic [8:0] pl_a  = '0;
  logic [7:0] pl_d  = '0;

  always_comb begin
    logic [8:0] a;
    a = mif.mem_addr[8:0];
    mif.mem_data_out = 32'd0;
    if (mif.mem_enable) begin
      case (mif.mem_length)
        2'b00: mif.mem_data_out = {{24{mif.mem_sign & mem[a][7]}}, mem[a]};
        2'b01: mif.mem_data_out = {{16{mif.mem_sign & mem[a][7]}}, mem[a], mem[a+9'd1]};
        2'b10: mif.mem_data_out = {mem[a], mem[a+9'd1], mem[a+9'd2], mem[a+9'd3]};
        default: mif.mem_data_out = 32'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    if (mif.mem_enable && mif.mem_wr) begin
      case (mif.mem_length)
        2'b00: mem[mif.mem_addr[8:0]] <= mif.mem_data_in[7:0];
        2'b01: begin
          mem[mif.mem_addr[8:0]]       <= mif.mem_data_in[15:8];
          mem[mif.mem_addr[8:0]+9'd1]  <= mif.mem_data_in[7:0];
        end
        2'b10: begin
          mem[mif.mem_addr[8:0]]       <= mif.mem_data_in[31:24];
          mem[mif.mem_addr[8:0]+9'd1]  <= mif.mem_data_in[23:16];
          mem[mif.mem_addr[8:0]+9'd2]  <= mif.mem_data_in[15:8];
          mem[mif.mem_addr[8:0]+9'd3]  <= mif.mem_data_in[7:0];
        end
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    tick();
    pl_we = 1'b0;
  endtask

  function automatic logic [138:0] all_outs();
    return {mif.if_gnt, mif.if_rvalid, mif.if_rdata, mif.dm_gnt, mif.dm_rvalid,
            mif.dm_rdata, mif.dm_err, mif.mem_enable, mif.mem_wr, mif.mem_addr,
            mif.mem_data_in, mif.mem_length, mif.mem_sign, busy};
  endfunction

  task automatic test_reset();
    mif.if_req = 0; mif.if_addr = 0;
    mif.dm_req = 0; mif.dm_wr = 0; mif.dm_addr = 0; mif.dm_wdata = 0;
    mif.dm_length = 0; mif.dm_sign = 0;
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    preload(9'h100, 8'h11); preload(9'h101, 8'h22);
    preload(9'h102, 8'h33); preload(9'h103, 8'h44);
    preload(9'h040, 8'h5A);
    rst = 1'b1;
    tick();
    n_chk++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_release_idle: got %h want 0", all_outs());
    end
  endtask

  task automatic test_if_read();
    mif.if_req = 1; mif.if_addr = 32'h100;
    tick();
    n_chk++;
    if ({mif.if_gnt, mif.dm_gnt, mif.mem_enable, mif.mem_wr, mif.mem_length, mif.mem_sign, busy} !== 8'b1010_1001) begin
      n_fail++; $display("FAIL if_acc_ctrl: got gnt=%b/%b en=%b wr=%b len=%b sgn=%b busy=%b want 1/0 1 0 10 0 1",
        mif.if_gnt, mif.dm_gnt, mif.mem_enable, mif.mem_wr, mif.mem_length, mif.mem_sign, busy);
    end
    n_chk++;
    if (mif.mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL if_acc_addr: got %h want 00000100", mif.mem_addr);
    end
    mif.if_req = 0;
    tick();
    n_chk++;
    if ({mif.if_rvalid, mif.if_gnt, mif.mem_enable, busy} !== 4'b1000 || mif.if_rdata !== 32'h11223344) begin
      n_fail++; $display("FAIL if_rvalid: got rv=%b gnt=%b en=%b busy=%b rdata=%h want 1 0 0 0 11223344",
        mif.if_rvalid, mif.if_gnt, mif.mem_enable, busy, mif.if_rdata);
    end
    tick();
    n_chk++;
    if (mif.if_rvalid !== 1'b0 || mif.if_rdata !== 32'h11223344) begin
      n_fail++; $display("FAIL if_rdata_hold: got rv=%b rdata=%h want 0 11223344", mif.if_rvalid, mif.if_rdata);
    end
  endtask

  task automatic test_dm_write_read();
    mif.dm_req = 1; mif.dm_wr = 1; mif.dm_addr = 32'h20; mif.dm_wdata = 32'hBEEF;
    mif.dm_length = 2'b01; mif.dm_sign = 0;
    tick();
    mif.dm_addr = 32'h99; mif.dm_wdata = 32'h1234;
    #1;
    n_chk++;
    if ({mif.dm_gnt, mif.mem_enable, mif.mem_wr, mif.mem_length} !== 5'b11101 ||
        mif.mem_addr !== 32'h20 || mif.mem_data_in !== 32'hBEEF) begin
      n_fail++; $display("FAIL dm_wr_acc: got gnt=%b en=%b wr=%b len=%b addr=%h din=%h want 1 1 1 01 00000020 0000beef",
        mif.dm_gnt, mif.mem_enable, mif.mem_wr, mif.mem_length, mif.mem_addr, mif.mem_data_in);
    end
    mif.dm_req = 0;
    tick();
    n_chk++;
    if ({mif.dm_rvalid, mif.dm_err} !== 2'b10 || mif.dm_rdata !== 32'd0) begin
      n_fail++; $display("FAIL dm_wr_ack: got rv=%b err=%b rdata=%h want 1 0 0", mif.dm_rvalid, mif.dm_err, mif.dm_rdata);
    end
    n_chk++;
    if ({mem[9'h20], mem[9'h21]} !== 16'hBEEF) begin
      n_fail++; $display("FAIL dm_wr_mem: got %h want beef", {mem[9'h20], mem[9'h21]});
    end
    mif.dm_req = 1; mif.dm_wr = 0; mif.dm_addr = 32'h20; mif.dm_length = 2'b00; mif.dm_sign = 1;
    tick();
    n_chk++;
    if (mif.dm_gnt !== 1'b1 || mif.mem_sign !== 1'b1) begin
      n_fail++; $display("FAIL dm_rd_gnt: got gnt=%b sgn=%b want 1 1", mif.dm_gnt, mif.mem_sign);
    end
    mif.dm_req = 0;
    tick();
    n_chk++;
    if (mif.dm_rvalid !== 1'b1 || mif.dm_rdata !== 32'hFFFFFFBE) begin
      n_fail++; $display("FAIL dm_rd_signed: got rv=%b rdata=%h want 1 ffffffbe", mif.dm_rvalid, mif.dm_rdata);
    end
    tick();
  endtask

  task automatic test_illegal_len();
    mif.dm_req = 1; mif.dm_wr = 0; mif.dm_addr = 32'h30; mif.dm_length = 2'b11; mif.dm_sign = 0;
    tick();
    n_chk++;
    if ({mif.dm_gnt, mif.mem_enable, busy} !== 3'b101) begin
      n_fail++; $display("FAIL illegal_acc: got gnt=%b en=%b busy=%b want 1 0 1", mif.dm_gnt, mif.mem_enable, busy);
    end
    mif.dm_req = 0; mif.dm_length = 2'b00;
    tick();
    n_chk++;
    if ({mif.dm_rvalid, mif.dm_err} !== 2'b11 || mif.dm_rdata !== 32'd0) begin
      n_fail++; $display("FAIL illegal_err: got rv=%b err=%b rdata=%h want 1 1 0", mif.dm_rvalid, mif.dm_err, mif.dm_rdata);
    end
    tick();
    n_chk++;
    if ({mif.dm_rvalid, mif.dm_err} !== 2'b00) begin
      n_fail++; $display("FAIL illegal_pulse: got rv=%b err=%b want 0 0", mif.dm_rvalid, mif.dm_err);
    end
  endtask

  task automatic test_drop_req();
    mif.dm_req = 1; mif.dm_wr = 0; mif.dm_addr = 32'h100; mif.dm_length = 2'b10;
    tick();
    mif.dm_req = 0; mif.if_req = 1; mif.if_addr = 32'h100;
    tick();
    mif.if_req = 0;
    tick();
    n_chk++;
    if ({mif.if_gnt, mif.dm_gnt, mif.mem_enable, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL drop_req: got ifg=%b dmg=%b en=%b busy=%b want 0 0 0 0",
        mif.if_gnt, mif.dm_gnt, mif.mem_enable, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    mif.if_req = 1; mif.if_addr = 32'h100;
    mif.dm_req = 1; mif.dm_wr = 0; mif.dm_addr = 32'h100; mif.dm_length = 2'b10; mif.dm_sign = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
`ifdef MEM_ARB_RR_EN
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = (k % 5 == 4) ? 2'b10 : 2'b01;
`endif
      n_chk++;
      if ({mif.if_gnt, mif.dm_gnt} !== exp_g) begin
        n_fail++; $display("FAIL contention_grant_%0d: got if/dm=%b want %b", k, {mif.if_gnt, mif.dm_gnt}, exp_g);
      end
      tick();
    end
    mif.if_req = 0; mif.dm_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    logic saw_rv;
    mif.dm_req = 1; mif.dm_wr = 1; mif.dm_addr = 32'h40; mif.dm_wdata = 32'hA5;
    mif.dm_length = 2'b00; mif.dm_sign = 0;
    tick();
    n_chk++;
    if ({mif.dm_gnt, mif.mem_enable, mif.mem_wr} !== 3'b111) begin
      n_fail++; $display("FAIL rstwr_acc: got gnt=%b en=%b wr=%b want 1 1 1", mif.dm_gnt, mif.mem_enable, mif.mem_wr);
    end
    #2 rst = 1'b0;
    mif.dm_req = 0; mif.dm_wr = 0;
    #1;
    n_chk++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL rstwr_outputs: got %h want 0", all_outs());
    end
    @(posedge clk); #1;
    @(negedge clk) rst = 1'b1;
    saw_rv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (mif.dm_rvalid !== 1'b0) saw_rv = 1'b1;
    end
    n_chk++;
    if (saw_rv !== 1'b0) begin
      n_fail++; $display("FAIL rstwr_no_rvalid: got rvalid seen=%b want 0", saw_rv);
    end
    n_chk++;
    if (mem[9'h40] !== 8'h5A) begin
      n_fail++; $display("FAIL rstwr_mem: got %h want 5a", mem[9'h40]);
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_write_read();
    test_illegal_len();
    test_drop_req();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
